// File: rtl/read_multiword.sv
// -----------------------------------------------------------------------------
// read_multiword
//   Tag-side responder for a Gen2 'read' command. Serialises the reply
//   header bit, wc sample words pulled serially from an external source
//   (adc or msp430), the current handle and, optionally, an inverted
//   CRC-16/CCITT over everything sent before it. One reply bit per
//   readbitclk edge. The tx module sees each new bit immediately after the
//   edge, because the outputs are decoded combinationally from the state.
//
// Parameters
//   SAMPLE_BITS  bits per sample word pulled from the source
//   MAX_WORDS    largest reply in words; wordcount 0 or above this is clamped
//   WC_BITS      width of the wordcount input
//   CRC_EN       1 = append inverted CRC-16; 0 = reply ends after the handle
//
// Ports
//   readbitclk          in   bit clock from the tx module, state on posedge
//   reset               in   asynchronous, active-high
//   handle              in   current handle (read live, not latched)
//   wordcount           in   words requested, latched on the INIT edge
//   read_sample_datain  in   serial sample data, MSB first
//   read_sample_ctl     out  request/enable to the sample source
//   read_sample_clk     out  sample shift clock, readbitclk gated by DATA
//   readbitout          out  current reply bit
//   readbitdone         out  reply complete
// -----------------------------------------------------------------------------
module read_multiword #(
   parameter int SAMPLE_BITS = 16,
   parameter int MAX_WORDS   = 4,
   parameter int WC_BITS     = 8,
   parameter bit CRC_EN      = 1'b1
) (
   input  logic               readbitclk,
   input  logic               reset,
   input  logic [15:0]        handle,
   input  logic [WC_BITS-1:0] wordcount,
   input  logic               read_sample_datain,
   output logic               read_sample_ctl,
   output logic               read_sample_clk,
   output logic               readbitout,
   output logic               readbitdone
);

   // The counter has to hold both the longest data field and the 16-bit
   // handle/CRC fields.
   localparam int DATA_MAX = MAX_WORDS * SAMPLE_BITS;
   localparam int CNT_W    = $clog2((DATA_MAX > 16) ? DATA_MAX : 16);
   localparam int WC_W     = $clog2(MAX_WORDS + 1);

   localparam logic [15:0] CRC_POLY   = 16'h1021;
   localparam logic [15:0] CRC_PRESET = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_HEADER,
      ST_DATA,
      ST_HANDLE,
      ST_CRC,
      ST_DONE
   } state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
   logic [WC_W-1:0]  wc, wc_next;
   logic [15:0]      crc, crc_next;
   logic             ctl_next;
   logic             crc_fb;

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge readbitclk or posedge reset) begin
      if (reset) begin
         state           <= ST_INIT;
         bit_cnt         <= '0;
         wc              <= '0;
         crc             <= CRC_PRESET;
         read_sample_ctl <= 1'b0;
      end else begin
         state           <= state_next;
         bit_cnt         <= bit_cnt_next;
         wc              <= wc_next;
         crc             <= crc_next;
         read_sample_ctl <= ctl_next;
      end
   end

   // Next-state logic. Counters count down to zero; the last bit of each
   // field is the one where bit_cnt reaches 0.
   // NOTE: every signal driven here gets a default first, so no path
   // through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_next   = state;
      bit_cnt_next = bit_cnt;
      wc_next      = wc;
      ctl_next     = read_sample_ctl;

      unique case (state)
         ST_INIT: begin
            if (wordcount == '0 || wordcount > WC_BITS'(MAX_WORDS))
               wc_next = WC_W'(MAX_WORDS);
            else
               wc_next = WC_W'(wordcount);
            ctl_next   = 1'b1;
            state_next = ST_HEADER;
         end
         ST_HEADER: begin
            bit_cnt_next = CNT_W'(int'(wc) * SAMPLE_BITS - 1);
            state_next   = ST_DATA;
         end
         ST_DATA: begin
            if (bit_cnt == '0) begin
               bit_cnt_next = CNT_W'(15);
               ctl_next     = 1'b0;
               state_next   = ST_HANDLE;
            end else begin
               bit_cnt_next = bit_cnt - 1'b1;
            end
         end
         ST_HANDLE: begin
            if (bit_cnt == '0) begin
               bit_cnt_next = CNT_W'(15);
               state_next   = CRC_EN ? ST_CRC : ST_DONE;
            end else begin
               bit_cnt_next = bit_cnt - 1'b1;
            end
         end
         ST_CRC: begin
            if (bit_cnt == '0)
               state_next = ST_DONE;
            else
               bit_cnt_next = bit_cnt - 1'b1;
         end
         ST_DONE: begin
            ctl_next = 1'b0;
         end
         default: begin
            state_next = ST_INIT;
         end
      endcase
   end

   // Serial CRC-16/CCITT, MSB first, fed with exactly the bit the tx module
   // is seeing this cycle. It freezes once the CRC field itself goes out.
   always_comb begin
      crc_fb   = crc[15] ^ readbitout;
      crc_next = crc;
      if (state == ST_HEADER || state == ST_DATA || state == ST_HANDLE)
         crc_next = {crc[14:0], 1'b0} ^ (crc_fb ? CRC_POLY : 16'h0000);
   end

   // Reply bit mux. The handle is read live, so a handle change during the
   // handle field shows up on the following bits.
   always_comb begin
      readbitout = 1'b0;
      unique case (state)
         ST_DATA:   readbitout = read_sample_datain;
         ST_HANDLE: readbitout = handle[bit_cnt[3:0]];
         ST_CRC:    readbitout = ~crc[bit_cnt[3:0]];
         default:   readbitout = 1'b0;
      endcase
   end

   assign readbitdone     = (state == ST_DONE);
   assign read_sample_clk = readbitclk & (state == ST_DATA);

endmodule

// File: tb/tb_read_multiword.sv
// -----------------------------------------------------------------------------
// tb_read_multiword
//   Drives two read_multiword instances in lock-step from shared inputs: one
//   with the CRC field enabled and one without. The expected reply is built
//   from the reply format (header, sample words, live handle, inverted
//   CRC-16) with a bit-level reference CRC, and every cycle checks reply bit,
//   done flag, sample control and sample clock of both instances.
// -----------------------------------------------------------------------------
module tb_read_multiword;

   localparam int SB = 16;
   localparam int MW = 4;

   logic        readbitclk = 1'b0;
   logic        reset      = 1'b1;
   logic [15:0] handle     = 16'h0000;
   logic [7:0]  wordcount  = 8'd1;
   logic        read_sample_datain = 1'b0;

   logic ctl1, sclk1, bit1, done1;
   logic ctl0, sclk0, bit0, done0;

   int vectors    = 0;
   int miscompares = 0;

   read_multiword #(.SAMPLE_BITS(SB), .MAX_WORDS(MW), .WC_BITS(8), .CRC_EN(1'b1)) dut_crc (
      .readbitclk         (readbitclk),
      .reset              (reset),
      .handle             (handle),
      .wordcount          (wordcount),
      .read_sample_datain (read_sample_datain),
      .read_sample_ctl    (ctl1),
      .read_sample_clk    (sclk1),
      .readbitout         (bit1),
      .readbitdone        (done1)
   );

   read_multiword #(.SAMPLE_BITS(SB), .MAX_WORDS(MW), .WC_BITS(8), .CRC_EN(1'b0)) dut_nocrc (
      .readbitclk         (readbitclk),
      .reset              (reset),
      .handle             (handle),
      .wordcount          (wordcount),
      .read_sample_datain (read_sample_datain),
      .read_sample_ctl    (ctl0),
      .read_sample_clk    (sclk0),
      .readbitout         (bit0),
      .readbitdone        (done0)
   );

   always #5 readbitclk = ~readbitclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference CRC-16/CCITT over a bit sequence, preset FFFF, MSB first.
   function automatic logic [15:0] crc_of(input bit q[$]);
      logic [15:0] c;
      bit fb;
      c = 16'hFFFF;
      foreach (q[i]) begin
         fb = c[15] ^ q[i];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ 16'h1021;
      end
      return c;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_bit1"},  bit1,  0);
      check({tag, "_done1"}, done1, 0);
      check({tag, "_ctl1"},  ctl1,  0);
      check({tag, "_sclk1"}, sclk1, 0);
      check({tag, "_bit0"},  bit0,  0);
      check({tag, "_done0"}, done0, 0);
      check({tag, "_ctl0"},  ctl0,  0);
      check({tag, "_sclk0"}, sclk0, 0);
   endtask

   task automatic do_reset();
      @(negedge readbitclk);
      reset = 1'b1;
      @(posedge readbitclk);
      #1 check_idle("reset");
      @(negedge readbitclk);
      reset = 1'b0;
   endtask

   // One reply, starting from INIT. abort_at > 0 asserts reset just after
   // that edge and returns; change_at > 0 scrambles wordcount after that
   // edge and changes the handle in the middle of the handle field.
   task automatic run_reply(input int wreq, input logic [15:0] h, input logic [15:0] w0,
                            input int abort_at, input int change_at, input int extra);
      int    wc_eff, d, len1, len0, pulses, pos;
      bit    src[$];
      bit    sent[$];
      bit    obs[$];
      logic  [15:0] word, crc_val;
      logic  e1, e0;

      wordcount = 8'(wreq);
      handle    = h;
      wc_eff    = (wreq == 0 || wreq > MW) ? MW : wreq;
      d         = wc_eff * SB;
      len1      = 1 + d + 32;
      len0      = 1 + d + 16;
      pulses    = 0;
      crc_val   = 16'h0000;
      for (int w = 0; w < wc_eff; w++) begin
         word = (w == 0) ? w0 : 16'($urandom);
         for (int b = 15; b >= 0; b--) src.push_back(word[b]);
      end

      for (int k = 1; k <= len1 + extra; k++) begin
         @(posedge readbitclk);
         #1;
         if (k == abort_at) begin
            reset = 1'b1;
            #1 check_idle("abort");
            @(negedge readbitclk);
            reset = 1'b0;
            return;
         end
         if (k == change_at) wordcount = 8'($urandom_range(0, 255));
         if (change_at != 0 && k == 1 + d + 8) handle = 16'($urandom);

         check("sclk1", sclk1, (k >= 2 && k <= 1 + d));
         check("sclk0", sclk0, (k >= 2 && k <= 1 + d));
         if (sclk1) pulses++;
         if (k >= 2 && k <= 1 + d) read_sample_datain = src[k-2];
         else                      read_sample_datain = 1'($urandom);

         @(negedge readbitclk);
         if (k <= 1 + d + 16) begin
            if (k == 1)           e1 = 1'b0;
            else if (k <= 1 + d)  e1 = src[k-2];
            else                  e1 = handle[15 - (k - 2 - d)];
            e0 = e1;
            sent.push_back(e1);
         end else if (k <= len1) begin
            if (k == 2 + d + 16) crc_val = crc_of(sent);
            pos = 15 - (k - 2 - d - 16);
            e1  = ~crc_val[pos];
            e0  = 1'b0;
         end else begin
            e1 = 1'b0;
            e0 = 1'b0;
         end
         check("bit1",  bit1,  e1);
         check("bit0",  bit0,  e0);
         check("done1", done1, (k > len1));
         check("done0", done0, (k > len0));
         check("ctl1",  ctl1,  (k <= 1 + d));
         check("ctl0",  ctl0,  (k <= 1 + d));
         if (k <= len1) obs.push_back(bit1);
      end
      check("pulses", pulses, d);
      check("residue", crc_of(obs), 16'h1D0F);
   endtask

   initial begin
      // Reset state before any edge is released.
      #2 check_idle("por");
      do_reset();

      // Single-word reply with known data.
      run_reply(1, 16'hBEEF, 16'h1234, 0, 0, 3);

      // Clamping: zero and oversize word counts both give MAX_WORDS.
      do_reset();
      run_reply(0, 16'($urandom), 16'($urandom), 0, 0, 2);
      do_reset();
      run_reply(200, 16'($urandom), 16'($urandom), 0, 0, 2);

      // Two words; the no-CRC instance ends after 49 bits.
      do_reset();
      run_reply(2, 16'($urandom), 16'($urandom), 0, 0, 2);

      // Abort mid-DATA, then a fresh reply with a different word count.
      do_reset();
      run_reply(3, 16'($urandom), 16'($urandom), 9, 0, 0);
      run_reply(2, 16'($urandom), 16'($urandom), 0, 0, 3);

      // wordcount scrambled mid-reply, live handle change, edges after DONE.
      do_reset();
      run_reply(2, 16'($urandom), 16'($urandom), 0, 5, 6);

      // Random replies.
      for (int i = 0; i < 4; i++) begin
         do_reset();
         run_reply(int'($urandom_range(0, 6)), 16'($urandom), 16'($urandom),
                   0, (i % 2 == 1) ? 3 : 0, 2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
